// File: rtl/axi_stream_sample_packetizer.sv
// rtl/axi_stream_sample_packetizer.sv - frames a tlast-less sample stream into header+payload packets
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            when low no packet opens and an open packet closes
//   in_tdata/tvalid   32-bit sample stream (no tlast)
//   in_tready         sample accept
//   out_tdata/tvalid/tlast/tready  packet stream: header {ID, seq} then 1..PKT_LEN samples
//   force_transmit    one-cycle pulse when a packet was closed by the idle timeout
module axi_stream_sample_packetizer #(
  parameter logic [7:0] ID      = 8'h00,
  parameter int         PKT_LEN = 63,
  parameter int         TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] in_tdata,
  input  logic        in_tvalid,
  output logic        in_tready,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  output logic        out_tlast,
  input  logic        out_tready,
  output logic        force_transmit
);

  localparam int CW = $clog2(PKT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

  state_t          state;
  logic [23:0]     seq;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   timer;
  logic [31:0]     hold;
  logic            hold_valid;
  logic            to_flag;
  logic            slot_free;
  logic            accept;

  assign slot_free = !out_tvalid || out_tready;
  assign in_tready = !rst && enable && slot_free && (state != CLOSE);
  assign accept    = in_tvalid && in_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      seq            <= 24'd0;
      cnt            <= '0;
      timer          <= '0;
      hold           <= 32'd0;
      hold_valid     <= 1'b0;
      to_flag        <= 1'b0;
      out_tdata      <= 32'd0;
      out_tvalid     <= 1'b0;
      out_tlast      <= 1'b0;
      force_transmit <= 1'b0;
    end else begin
      force_transmit <= 1'b0;
      // A consumed word leaves the slot empty unless something is loaded below.
      if (out_tready) out_tvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            out_tdata  <= {ID, seq};
            out_tvalid <= 1'b1;
            out_tlast  <= 1'b0;
            hold       <= in_tdata;
            hold_valid <= 1'b1;
            cnt        <= CW'(1);
            timer      <= '0;
            state      <= (PKT_LEN == 1) ? CLOSE : OPEN;
          end
        end

        OPEN: begin
          if (accept) begin
            // The held sample moves out; the new one waits in case it ends the packet.
            out_tdata  <= hold;
            out_tvalid <= 1'b1;
            out_tlast  <= 1'b0;
            hold       <= in_tdata;
            cnt        <= cnt + CW'(1);
            timer      <= '0;
            if (cnt == CW'(PKT_LEN - 1)) state <= CLOSE;
          end else if (!enable) begin
            state   <= CLOSE;
            to_flag <= 1'b0;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state   <= CLOSE;
            to_flag <= 1'b1;
          end else if (timer != TW'(TIMEOUT)) begin
            timer <= timer + TW'(1);
          end
        end

        CLOSE: begin
          if (slot_free) begin
            out_tdata      <= hold;
            out_tvalid     <= hold_valid;
            out_tlast      <= 1'b1;
            hold_valid     <= 1'b0;
            seq            <= seq + 24'd1;
            force_transmit <= to_flag;
            to_flag        <= 1'b0;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_sample_packetizer.sv
// tb/tb_axi_stream_sample_packetizer.sv - randomized bench with packet-level reference model
module tb_axi_stream_sample_packetizer;

  localparam logic [7:0] ID0 = 8'h5A;
  localparam int         PL0 = 4;
  localparam int         TO0 = 16;
  localparam logic [7:0] ID1 = 8'h3C;
  localparam int         PL1 = 1;
  localparam int         TO1 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] in_tdata;
  logic        in_tvalid;
  logic        out_tready;
  logic [1:0]  itr, ov, ol, ftp;
  logic [31:0] od [2];

  always #5 clk = ~clk;

  axi_stream_sample_packetizer #(.ID(ID0), .PKT_LEN(PL0), .TIMEOUT(TO0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(itr[0]),
    .out_tdata(od[0]), .out_tvalid(ov[0]), .out_tlast(ol[0]), .out_tready(out_tready),
    .force_transmit(ftp[0])
  );

  axi_stream_sample_packetizer #(.ID(ID1), .PKT_LEN(PL1), .TIMEOUT(TO1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(itr[1]),
    .out_tdata(od[1]), .out_tvalid(ov[1]), .out_tlast(ol[1]), .out_tready(out_tready),
    .force_transmit(ftp[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected word stream per instance. [32]=tlast, [33]=closed by timeout.
  logic [33:0] expq [2][0:8191];
  int          wr [2];
  int          rd [2];
  bit          m_open [2];
  int          m_cnt [2];
  int          m_idle [2];
  logic [23:0] m_seq [2];
  int          exp_ft [2];
  int          got_ft [2];
  bit          prev_stall [2];
  logic [32:0] prev_word [2];
  bit          prev_ft [2];
  logic [32:0] cap [2][0:63];
  int          ncap [2];

  task automatic model_close(input int k, input bit to);
    expq[k][wr[k]-1][32] = 1'b1;
    expq[k][wr[k]-1][33] = to;
    m_open[k] = 1'b0;
    m_seq[k]  = m_seq[k] + 24'd1;
    if (to) exp_ft[k]++;
  endtask

  // Evaluated on the falling edge: describes the handshakes of the coming rising edge.
  task automatic mon(input int k);
    int          pl;
    int          tmo;
    logic [7:0]  idv;
    pl  = (k == 0) ? PL0 : PL1;
    tmo = (k == 0) ? TO0 : TO1;
    idv = (k == 0) ? ID0 : ID1;
    if (rst) begin
      m_open[k] = 1'b0; m_idle[k] = 0; m_cnt[k] = 0; m_seq[k] = 24'd0;
      wr[k] = 0; rd[k] = 0; prev_stall[k] = 1'b0; prev_ft[k] = 1'b0;
      return;
    end
    if (prev_stall[k])
      check($sformatf("stall_hold%0d", k), {ov[k], ol[k], od[k]}, {1'b1, prev_word[k]});
    prev_stall[k] = ov[k] && !out_tready;
    prev_word[k]  = {ol[k], od[k]};

    if (!enable) check($sformatf("tready_en_low%0d", k), itr[k], 1'b0);

    if (ftp[k]) begin
      got_ft[k]++;
      check($sformatf("ft_single%0d", k), prev_ft[k], 1'b0);
      check($sformatf("ft_word%0d", k), {ov[k], ol[k], (rd[k] < wr[k]) ? expq[k][rd[k]][33] : 1'b0}, 3'b111);
    end
    prev_ft[k] = ftp[k];

    if (ov[k] && out_tready) begin
      if (rd[k] >= wr[k]) begin
        check($sformatf("extra_word%0d", k), {ol[k], od[k]}, 33'h0_dead_beef);
      end else begin
        check($sformatf("word%0d_%0d", k, rd[k]), {ol[k], od[k]}, expq[k][rd[k]][32:0]);
        rd[k]++;
      end
      if (ncap[k] < 64) cap[k][ncap[k]] = {ol[k], od[k]};
      ncap[k]++;
    end

    if (in_tvalid && itr[k]) begin
      if (!m_open[k]) begin
        expq[k][wr[k]] = {2'b00, idv, m_seq[k]};
        wr[k]++;
        m_open[k] = 1'b1;
        m_cnt[k]  = 0;
      end
      expq[k][wr[k]] = {2'b00, in_tdata};
      wr[k]++;
      m_cnt[k]++;
      m_idle[k] = 0;
      if (m_cnt[k] == pl) model_close(k, 1'b0);
    end else if (m_open[k]) begin
      m_idle[k]++;
      if (!enable) model_close(k, 1'b0);
      else if (m_idle[k] == tmo) model_close(k, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [31:0] v);
    bit acc;
    acc = 1'b0;
    in_tdata  = v;
    in_tvalid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = itr[k];
      tick();
    end
    if (!acc) check($sformatf("send_timeout%0d", k), 1'b0, 1'b1);
    in_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_tvalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic cmp_cap(input int k, input int i, input logic [32:0] e);
    check($sformatf("cap%0d_%0d", k, i), (i < 64) ? cap[k][i] : 33'h1_ffff_ffff, e);
  endtask

  logic [32:0] e1 [10];
  logic [23:0] s;
  int          ft0;
  logic [31:0] data;
  bit          acc0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      wr[k] = 0; rd[k] = 0; m_open[k] = 0; m_cnt[k] = 0; m_idle[k] = 0; m_seq[k] = 0;
      exp_ft[k] = 0; got_ft[k] = 0; prev_stall[k] = 0; prev_ft[k] = 0; ncap[k] = 0;
    end
    rst = 1'b1; enable = 1'b1; in_tvalid = 1'b1; in_tdata = 32'h1234; out_tready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_tready", itr, 2'b00);
    check("rst_tvalid", ov, 2'b00);
    check("rst_tlast", ol, 2'b00);
    check("rst_tdata0", od[0], 32'h0);
    check("rst_ft", ftp, 2'b00);
    tick();
    rst = 1'b0; in_tvalid = 1'b0;
    tick();

    // Full packets, unstalled
    ncap[0] = 0;
    for (int i = 1; i <= 8; i++) send(0, i);
    idle(6);
    e1 = '{33'h0_5A00_0000, 33'h0_0000_0001, 33'h0_0000_0002, 33'h0_0000_0003, 33'h1_0000_0004,
           33'h0_5A00_0001, 33'h0_0000_0005, 33'h0_0000_0006, 33'h0_0000_0007, 33'h1_0000_0008};
    check("full_ncap", ncap[0], 10);
    for (int i = 0; i < 10; i++) cmp_cap(0, i, e1[i]);
    check("full_ft", got_ft[0], 0);

    // Random backpressure, random valid, occasional enable drops
    data = 32'h100;
    for (int c = 0; c < 400; c++) begin
      out_tready = $urandom_range(0, 1);
      in_tvalid  = $urandom_range(0, 1);
      enable     = ($urandom_range(0, 31) != 0);
      in_tdata   = data;
      @(negedge clk);
      acc0 = in_tvalid && itr[0];
      tick();
      if (acc0) data++;
    end
    enable = 1'b1; out_tready = 1'b1;
    idle(30);

    // Timeout closure
    ncap[0] = 0; s = m_seq[0]; ft0 = got_ft[0];
    send(0, 32'hA);
    send(0, 32'hB);
    idle(24);
    check("to_ft", got_ft[0] - ft0, 1);
    send(0, 32'hC);
    idle(24);
    check("to_ncap", ncap[0], 5);
    cmp_cap(0, 0, {1'b0, ID0, s});
    cmp_cap(0, 1, 33'h0_0000_000A);
    cmp_cap(0, 2, 33'h1_0000_000B);
    cmp_cap(0, 3, {1'b0, ID0, s + 24'd1});
    cmp_cap(0, 4, 33'h1_0000_000C);

    // Enable drop after 3 samples
    ncap[0] = 0; s = m_seq[0]; ft0 = got_ft[0];
    send(0, 32'h41);
    send(0, 32'h42);
    send(0, 32'h43);
    enable = 1'b0; in_tvalid = 1'b1; in_tdata = 32'h44;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("en_low_tready", itr[0], 1'b0);
      tick();
    end
    in_tvalid = 1'b0; enable = 1'b1;
    check("en_ncap", ncap[0], 4);
    cmp_cap(0, 0, {1'b0, ID0, s});
    cmp_cap(0, 3, 33'h1_0000_0043);
    check("en_ft", got_ft[0] - ft0, 0);
    send(0, 32'h45);
    idle(24);
    cmp_cap(0, 4, {1'b0, ID0, s + 24'd1});

    // PKT_LEN = 1 instance
    ncap[1] = 0; s = m_seq[1];
    send(1, 32'h7);
    send(1, 32'h8);
    idle(24);
    check("pl1_ncap", ncap[1], 4);
    cmp_cap(1, 0, {1'b0, ID1, s});
    cmp_cap(1, 1, 33'h1_0000_0007);
    cmp_cap(1, 2, {1'b0, ID1, s + 24'd1});
    cmp_cap(1, 3, 33'h1_0000_0008);

    // Reset mid-packet
    send(0, 32'h11);
    send(0, 32'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", ov[0], 1'b0);
    check("midrst_tlast", ol[0], 1'b0);
    tick();
    ncap[0] = 0;
    send(0, 32'h33);
    idle(24);
    check("midrst_ncap", ncap[0], 2);
    cmp_cap(0, 0, {1'b0, ID0, 24'h0});
    cmp_cap(0, 1, 33'h1_0000_0033);

    idle(10);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("drained%0d", k), rd[k], wr[k]);
      check($sformatf("closed%0d", k), m_open[k], 1'b0);
      check($sformatf("ft_count%0d", k), got_ft[k], exp_ft[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_stream_sample_packetizer.md
Name: axi_stream_sample_packetizer

Overview:
Frames a continuous 32-bit sample stream with no tlast into AXI Stream packets. Each packet is one header word followed by up to PKT_LEN payload words.
Sits directly upstream of the packet combiner: out_* feeds its in_* and force_transmit drives its force_transmit input.
Packets close on reaching PKT_LEN, on an input timeout, or when enable drops. A timeout closure pulses force_transmit so the combiner flushes a partially filled combined packet.

Parameters:
ID, 0, 8-bit source identifier placed in header bits [31:24]
PKT_LEN, 63, payload words per full packet; legal range 1..63, so header plus payload fits in 64 words
TIMEOUT, 1024, idle cycles (no sample accepted) after which an open packet closes; must be at least 1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
enable  in  1  packetizing enable; when low, no new packet opens and an open packet closes
in_tdata  in  32  sample data
in_tvalid  in  1  sample valid
in_tready  out  1  sample accept
out_tdata  out  32  packet data
out_tvalid  out  1  packet data valid
out_tlast  out  1  last word of packet
out_tready  in  1  downstream accept
force_transmit  out  1  single-cycle pulse marking a timeout closure

Behaviour:
- Reset: all state synchronous on rst.
  - out_tvalid=0, out_tlast=0, out_tdata=0, force_transmit=0.
  - in_tready=0 while rst is high.
  - state=IDLE, seq=0, cnt=0, timer=0, hold_valid=0.
  - rst mid-packet discards the open packet; the partial packet is never completed.
- Storage: a registered output slot (out_tdata, out_tvalid, out_tlast) and a one-word hold register (hold, hold_valid).
  - slot_free = !out_tvalid || out_tready.
  - Output words are registered, not combinational from the input.
  - Output slot contents are stable while out_tvalid && !out_tready.
- Header word = {ID[7:0], seq[23:0]}. seq increments by 1 when a packet's tlast word is loaded, and wraps from 0xFFFFFF to 0.
- The hold register delays each sample by one word, so the packet's final sample can carry tlast when the closure is decided later.
- States:
  - IDLE:
    - in_tready = enable && slot_free.
    - On accept: slot<=header (last=0), hold<=sample, hold_valid=1, cnt=1, timer=0.
    - Next state is CLOSE if PKT_LEN==1, else OPEN.
  - OPEN:
    - in_tready = enable && slot_free.
    - On accept: slot<=hold (last=0), hold<=sample, cnt<=cnt+1, timer<=0.
    - If cnt+1==PKT_LEN, go to CLOSE (full).
    - With no accept, timer increments each cycle. When timer==TIMEOUT-1, go to CLOSE and set to_flag=1.
    - enable low with no accept: go to CLOSE, to_flag=0.
    - Full has priority over timeout in the same cycle; an accept always resets timer.
  - CLOSE:
    - in_tready=0.
    - When slot_free: slot<=hold with last=1, hold_valid=0, seq++, force_transmit=to_flag for exactly that cycle, to_flag<=0, go to IDLE.
- Latency:
  - Header appears on out_tvalid 1 cycle after the first sample is accepted.
  - Sample n appears 1 cycle after sample n+1 is accepted, or 1 cycle after CLOSE finds slot_free.
  - Minimum inter-packet gap is 1 cycle (the CLOSE state).
- Packet length on output is cnt+1 words (header plus cnt payload words), with 1 ≤ cnt ≤ PKT_LEN. No empty packets are produced.
- Widths: cnt is clog2(PKT_LEN+1) bits. timer is clog2(TIMEOUT+1) bits and saturates; it never wraps.
- force_transmit is never asserted for full or enable-low closures.

Test Plan:
- Full packets, unstalled: ID=0x5A, PKT_LEN=4, enable=1, out_tready=1, samples 1..8 back-to-back -> output 0x5A000000,1,2,3,4(last),0x5A000001,5,6,7,8(last); force_transmit never high.
- Random backpressure: same stimulus with out_tready random ~50% and in_tvalid random -> identical word sequence with no loss or duplication; out_tdata/out_tlast stable whenever out_tvalid && !out_tready.
- Timeout closure: TIMEOUT=16, PKT_LEN=4, samples 0xA,0xB then in_tvalid=0 -> header, 0xA, then 0xB with tlast after 16 idle cycles; force_transmit high exactly 1 cycle, coincident with loading 0xB; next header carries seq+1.
- Enable drop: enable falls after 3 samples accepted -> 3rd sample emitted with tlast; force_transmit stays 0; in_tready=0 until enable returns; next packet opens only after enable=1.
- PKT_LEN=1: samples 7,8 -> header0,7(last),header1,8(last); each packet is 2 words.
- Reset mid-packet: rst for 1 cycle after 2 samples -> next cycle out_tvalid=0 and out_tlast=0; the following packet's header = {ID,24'h0}; no stale hold word is emitted.
